// File: rtl/branch_update_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_update_ctrl_pkg
//   Shared definitions for the branch bookkeeping controller and its queue:
//   FSM state encodings, queue entry layout, PC width and the opcode
//   constants already used on the predictor side.
// ---------------------------------------------------------------------------
package branch_update_ctrl_pkg;

    localparam int PC_W    = 32;
    localparam int ENTRY_W = PC_W + 1;

    // FSM state encodings
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_RECOVER = 1'b1;

    // Predictor-side opcode constants
    localparam logic [1:0] BP_OP_NOP      = 2'd0;
    localparam logic [1:0] BP_OP_TRAIN    = 2'd1;
    localparam logic [1:0] BP_OP_REDIRECT = 2'd2;

    // One in-flight branch: predicted direction plus the PC to fetch
    // if that prediction turns out wrong.
    typedef struct packed {
        logic            pred;
        logic [PC_W-1:0] alt_pc;
    } bq_entry_t;

    function automatic bq_entry_t bq_pack(input logic pred, input logic [PC_W-1:0] alt_pc);
        bq_entry_t e;
        e.pred   = pred;
        e.alt_pc = alt_pc;
        return e;
    endfunction

endpackage

// File: rtl/branch_update_ctrl_queue_fifo.sv
// ---------------------------------------------------------------------------
// branch_queue_fifo
//   Circular FIFO of in-flight branch entries.
//   Ports:
//     clk_i, rst_ni  - clock, asynchronous active-low reset
//     clear_i        - synchronous clear; wins over push and pop
//     push_i         - write push_data_i at the tail (ignored when full)
//     pop_i          - drop the head entry (ignored when empty)
//     head_o         - oldest entry (valid only when !empty_o)
//     count_o        - occupied entries, PTR_W+1 bits
//     full_o/empty_o - occupancy flags
// ---------------------------------------------------------------------------
module branch_queue_fifo
    import branch_update_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  bq_entry_t        push_data_i,
    input  logic             pop_i,
    output bq_entry_t        head_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);

    bq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // DEPTH is a power of two, so plain PTR_W-bit increments wrap correctly.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; a write during clear lands in a slot that is
    // already considered empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/branch_update_ctrl.sv
// ---------------------------------------------------------------------------
// branch_update_ctrl
//   In-order branch bookkeeping between fetch, execute and the predictor.
//   Fetch enqueues predicted branches; execute resolves them in order. Each
//   resolve produces a one-cycle training strobe; a mispredict also produces
//   a one-cycle redirect + flush, clears the queue and holds off fetch for
//   RECOVER_CYCLES cycles.
//   Ports:
//     clk, rst (async, active low)
//     enq_valid/enq_ready/enq_pred/enq_alt_pc   - fetch enqueue handshake
//     res_valid/res_taken                       - execute resolve
//     upd_branch/upd_result                     - predictor training
//     redirect_valid/redirect_pc/flush          - mispredict recovery
//     count, err_underflow                      - status
//     stat_branches/stat_mispredicts            - optional statistics
//     dbg_state                                 - current FSM state
//   Handshake: an entry is taken on a rising edge where enq_valid and
//   enq_ready are both 1; enq_ready depends on registered state only.
//   Optional feature macro: BRANCH_STATS_EN enables the statistic counters;
//   when undefined both stat ports are tied to 0.
// ---------------------------------------------------------------------------
module branch_update_ctrl
    import branch_update_ctrl_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int PTR_W          = 2,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enq_valid,
    output logic            enq_ready,
    input  logic            enq_pred,
    input  logic [31:0]     enq_alt_pc,
    input  logic            res_valid,
    input  logic            res_taken,
    output logic            upd_branch,
    output logic            upd_result,
    output logic            redirect_valid,
    output logic [31:0]     redirect_pc,
    output logic            flush,
    output logic [PTR_W:0]  count,
    output logic            err_underflow,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts,
    output logic [0:0]      dbg_state
);

    bq_entry_t      head;
    logic [PTR_W:0] q_count;
    logic           q_full, q_empty;
    logic           enq_fire, pop, mispredict, underflow;

    logic [0:0]     state_q, state_d;
    logic [3:0]     rcnt_q, rcnt_d;
    logic           alive_q;
    logic           upd_branch_q, upd_result_q;
    logic           redirect_q, flush_q;
    logic [31:0]    redirect_pc_q;
    logic           err_q;

    // alive_q keeps enq_ready low while in reset and through the release
    // cycle, so fetch sees the queue open on the first clock after reset.
    assign enq_ready  = alive_q && (state_q == ST_RUN) && !q_full;
    assign enq_fire   = enq_valid && enq_ready;
    assign pop        = res_valid && !q_empty;
    assign mispredict = pop && (res_taken != head.pred);
    assign underflow  = res_valid && q_empty;

    // Clearing on mispredict also drops any entry pushed in the same cycle.
    branch_queue_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_queue (
        .clk_i       (clk),
        .rst_ni      (rst),
        .clear_i     (mispredict),
        .push_i      (enq_fire),
        .push_data_i (bq_pack(enq_pred, enq_alt_pc)),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (q_count),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    // Recovery counter is loaded with RECOVER_CYCLES and RUN is re-entered
    // on the edge where it reads 1, giving RECOVER_CYCLES cycles of stall.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        if (mispredict) begin
            state_d = ST_RECOVER;
            rcnt_d  = 4'(RECOVER_CYCLES);
        end else if (state_q == ST_RECOVER) begin
            if (rcnt_q <= 4'd1) begin
                state_d = ST_RUN;
                rcnt_d  = 4'd0;
            end else begin
                rcnt_d = rcnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            rcnt_q        <= 4'd0;
            alive_q       <= 1'b0;
            upd_branch_q  <= 1'b0;
            upd_result_q  <= 1'b0;
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            alive_q      <= 1'b1;
            upd_branch_q <= pop;
            upd_result_q <= pop && res_taken;
            redirect_q   <= mispredict;
            flush_q      <= mispredict;
            if (mispredict) redirect_pc_q <= head.alt_pc;
            err_q        <= err_q || underflow;
        end
    end

    assign upd_branch     = upd_branch_q;
    assign upd_result     = upd_result_q;
    assign redirect_valid = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign count          = q_count;
    assign err_underflow  = err_q;
    assign dbg_state      = state_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (pop)        stat_br_q <= stat_br_q + 32'd1;
            if (mispredict) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_update_ctrl.sv
module tb_branch_update_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid;
    logic        enq_ready;
    logic        enq_pred;
    logic [31:0] enq_alt_pc;
    logic        res_valid;
    logic        res_taken;
    logic        upd_branch;
    logic        upd_result;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [2:0]  count;
    logic        err_underflow;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
    logic [0:0]  dbg_state;

    int total = 0;
    int bad   = 0;

`ifdef BRANCH_STATS_EN
    localparam logic [31:0] EXP_BR = 32'd9;
    localparam logic [31:0] EXP_MP = 32'd4;
`else
    localparam logic [31:0] EXP_BR = 32'd0;
    localparam logic [31:0] EXP_MP = 32'd0;
`endif

    // clock / reset
    always #5 clk = ~clk;

    branch_update_ctrl #(
        .DEPTH          (4),
        .PTR_W          (2),
        .RECOVER_CYCLES (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enq_valid        (enq_valid),
        .enq_ready        (enq_ready),
        .enq_pred         (enq_pred),
        .enq_alt_pc       (enq_alt_pc),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .upd_branch       (upd_branch),
        .upd_result       (upd_result),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .count            (count),
        .err_underflow    (err_underflow),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
        .dbg_state        (dbg_state)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic p, input logic [31:0] pc);
        enq_valid  = 1'b1;
        enq_pred   = p;
        enq_alt_pc = pc;
        tick();
        enq_valid  = 1'b0;
    endtask

    task automatic resolve(input logic t);
        res_valid = 1'b1;
        res_taken = t;
        tick();
        res_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        enq_valid  = 1'b0;
        enq_pred   = 1'b0;
        enq_alt_pc = 32'd0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;

        // reset state
        tick();
        tick();
        check("rst_enq_ready", {31'd0, enq_ready}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_upd_branch", {31'd0, upd_branch}, 32'd0);
        check("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_err", {31'd0, err_underflow}, 32'd0);
        check("rst_state", {31'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rel_enq_ready", {31'd0, enq_ready}, 32'd1);

        // basic correct prediction
        push(1'b1, 32'h100);
        check("basic_count1", {29'd0, count}, 32'd1);
        resolve(1'b1);
        check("basic_upd_branch", {31'd0, upd_branch}, 32'd1);
        check("basic_upd_result", {31'd0, upd_result}, 32'd1);
        check("basic_redirect", {31'd0, redirect_valid}, 32'd0);
        check("basic_count0", {29'd0, count}, 32'd0);
        tick();
        check("basic_upd_pulse", {31'd0, upd_branch}, 32'd0);

        // mispredict with younger entries behind it
        push(1'b0, 32'h200);
        push(1'b1, 32'h300);
        push(1'b1, 32'h400);
        check("mis_count3", {29'd0, count}, 32'd3);
        resolve(1'b1);
        check("mis_redirect", {31'd0, redirect_valid}, 32'd1);
        check("mis_redirect_pc", redirect_pc, 32'h200);
        check("mis_flush", {31'd0, flush}, 32'd1);
        check("mis_count0", {29'd0, count}, 32'd0);
        check("mis_upd_branch", {31'd0, upd_branch}, 32'd1);
        check("mis_upd_result", {31'd0, upd_result}, 32'd1);
        check("mis_ready_c1", {31'd0, enq_ready}, 32'd0);
        check("mis_state", {31'd0, dbg_state}, 32'd1);
        tick();
        check("mis_ready_c2", {31'd0, enq_ready}, 32'd0);
        check("mis_redirect_pulse", {31'd0, redirect_valid}, 32'd0);
        check("mis_flush_pulse", {31'd0, flush}, 32'd0);
        check("mis_pc_hold", redirect_pc, 32'h200);
        tick();
        check("mis_ready_c3", {31'd0, enq_ready}, 32'd1);
        check("mis_state_run", {31'd0, dbg_state}, 32'd0);

        // full queue with enq_valid held high
        enq_valid = 1'b1;
        enq_pred  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enq_alt_pc = 32'h500 + i;
            tick();
        end
        check("full_count", {29'd0, count}, 32'd4);
        check("full_ready", {31'd0, enq_ready}, 32'd0);
        enq_alt_pc = 32'h5ff;
        tick();
        check("full_hold_count", {29'd0, count}, 32'd4);
        res_valid = 1'b1;
        res_taken = 1'b0;
        tick();
        res_valid = 1'b0;
        enq_valid = 1'b0;
        check("full_pop_count", {29'd0, count}, 32'd3);
        check("full_pop_ready", {31'd0, enq_ready}, 32'd1);
        check("full_pop_upd", {31'd0, upd_branch}, 32'd1);
        check("full_pop_result", {31'd0, upd_result}, 32'd0);
        check("full_pop_redirect", {31'd0, redirect_valid}, 32'd0);
        resolve(1'b0);
        resolve(1'b0);
        check("full_drain_count", {29'd0, count}, 32'd1);
        resolve(1'b1);
        check("full_last_redirect", {31'd0, redirect_valid}, 32'd1);
        check("full_last_pc", redirect_pc, 32'h503);
        tick();
        tick();
        check("full_recover_ready", {31'd0, enq_ready}, 32'd1);

        // enqueue and mispredicting resolve in the same cycle
        push(1'b1, 32'h600);
        push(1'b0, 32'h700);
        check("sim_count2", {29'd0, count}, 32'd2);
        enq_valid  = 1'b1;
        enq_pred   = 1'b1;
        enq_alt_pc = 32'h800;
        res_valid  = 1'b1;
        res_taken  = 1'b0;
        tick();
        enq_valid = 1'b0;
        res_valid = 1'b0;
        check("sim_count0", {29'd0, count}, 32'd0);
        check("sim_redirect_pc", redirect_pc, 32'h600);
        check("sim_flush", {31'd0, flush}, 32'd1);
        tick();
        tick();
        check("sim_ready", {31'd0, enq_ready}, 32'd1);
        check("sim_count_after", {29'd0, count}, 32'd0);

        // enqueue and correct resolve in the same cycle
        push(1'b1, 32'h900);
        enq_valid  = 1'b1;
        enq_pred   = 1'b0;
        enq_alt_pc = 32'ha00;
        res_valid  = 1'b1;
        res_taken  = 1'b1;
        tick();
        enq_valid = 1'b0;
        res_valid = 1'b0;
        check("both_count", {29'd0, count}, 32'd1);
        check("both_upd", {31'd0, upd_branch}, 32'd1);
        check("both_redirect", {31'd0, redirect_valid}, 32'd0);
        resolve(1'b1);
        check("both_new_redirect", {31'd0, redirect_valid}, 32'd1);
        check("both_new_pc", redirect_pc, 32'ha00);
        tick();
        tick();

        // underflow
        check("uf_empty", {29'd0, count}, 32'd0);
        resolve(1'b1);
        check("uf_err", {31'd0, err_underflow}, 32'd1);
        check("uf_no_upd", {31'd0, upd_branch}, 32'd0);
        check("uf_no_redirect", {31'd0, redirect_valid}, 32'd0);
        tick();
        check("uf_sticky", {31'd0, err_underflow}, 32'd1);

        // statistics before reset
        check("stat_branches", stat_branches, EXP_BR);
        check("stat_mispredicts", stat_mispredicts, EXP_MP);

        // asynchronous reset during recovery
        push(1'b0, 32'hb00);
        resolve(1'b1);
        check("rr_redirect", {31'd0, redirect_valid}, 32'd1);
        tick();
        check("rr_in_recover", {31'd0, enq_ready}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("rr_async_ready", {31'd0, enq_ready}, 32'd0);
        check("rr_async_state", {31'd0, dbg_state}, 32'd0);
        check("rr_async_pc", redirect_pc, 32'd0);
        check("rr_async_err", {31'd0, err_underflow}, 32'd0);
        check("rr_async_count", {29'd0, count}, 32'd0);
        check("rr_async_stat_br", stat_branches, 32'd0);
        check("rr_async_stat_mp", stat_mispredicts, 32'd0);
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rr_release_ready", {31'd0, enq_ready}, 32'd1);
        check("rr_release_count", {29'd0, count}, 32'd0);
        check("rr_release_err", {31'd0, err_underflow}, 32'd0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
